// File: rtl/axil_arbiter_2x1.sv
// axil_arbiter_2x1: two AXI4-Lite masters onto one register slave.
// Read and write directions are arbitrated independently, round-robin, one outstanding each.
module axil_arbiter_2x1 #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    mpsoc_clk_100,
    input  logic                    axil_arst_n,
    input  logic [ADDR_WIDTH-1:0]   s0_axil_awaddr,
    input  logic [2:0]              s0_axil_awprot,
    input  logic                    s0_axil_awvalid,
    output logic                    s0_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axil_wstrb,
    input  logic                    s0_axil_wvalid,
    output logic                    s0_axil_wready,
    output logic [1:0]              s0_axil_bresp,
    output logic                    s0_axil_bvalid,
    input  logic                    s0_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axil_araddr,
    input  logic [2:0]              s0_axil_arprot,
    input  logic                    s0_axil_arvalid,
    output logic                    s0_axil_arready,
    output logic [DATA_WIDTH-1:0]   s0_axil_rdata,
    output logic [1:0]              s0_axil_rresp,
    output logic                    s0_axil_rvalid,
    input  logic                    s0_axil_rready,
    input  logic [ADDR_WIDTH-1:0]   s1_axil_awaddr,
    input  logic [2:0]              s1_axil_awprot,
    input  logic                    s1_axil_awvalid,
    output logic                    s1_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axil_wstrb,
    input  logic                    s1_axil_wvalid,
    output logic                    s1_axil_wready,
    output logic [1:0]              s1_axil_bresp,
    output logic                    s1_axil_bvalid,
    input  logic                    s1_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axil_araddr,
    input  logic [2:0]              s1_axil_arprot,
    input  logic                    s1_axil_arvalid,
    output logic                    s1_axil_arready,
    output logic [DATA_WIDTH-1:0]   s1_axil_rdata,
    output logic [1:0]              s1_axil_rresp,
    output logic                    s1_axil_rvalid,
    input  logic                    s1_axil_rready,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready
);

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic     w_gnt_q, w_gnt_d, w_last_q, w_last_d;
    logic     aw_done_q, aw_done_d, wd_done_q, wd_done_d;
    logic     r_gnt_q, r_gnt_d, r_last_q, r_last_d;
    logic     w_xfer, w_resp, w_act, r_addr, r_data, r_act;
    logic     aw_hs, wd_hs, b_hs, ar_hs, rd_hs, aw_ok, wd_ok;

    assign w_xfer = (w_state_q == W_XFER);
    assign w_resp = (w_state_q == W_RESP);
    assign w_act  = (w_state_q != W_IDLE);
    assign r_addr = (r_state_q == R_ADDR);
    assign r_data = (r_state_q == R_DATA);
    assign r_act  = (r_state_q != R_IDLE);
    assign aw_hs  = m_axil_awvalid & m_axil_awready;
    assign wd_hs  = m_axil_wvalid & m_axil_wready;
    assign b_hs   = m_axil_bvalid & m_axil_bready;
    assign ar_hs  = m_axil_arvalid & m_axil_arready;
    assign rd_hs  = m_axil_rvalid & m_axil_rready;
    assign aw_ok  = aw_done_q | aw_hs;
    assign wd_ok  = wd_done_q | wd_hs;

    always_ff @(posedge mpsoc_clk_100) begin
        if (!axil_arst_n) begin
            w_state_q <= W_IDLE;
            w_gnt_q   <= 1'b0;
            w_last_q  <= 1'b1;
            aw_done_q <= 1'b0;
            wd_done_q <= 1'b0;
            r_state_q <= R_IDLE;
            r_gnt_q   <= 1'b0;
            r_last_q  <= 1'b1;
        end else begin
            w_state_q <= w_state_d;
            w_gnt_q   <= w_gnt_d;
            w_last_q  <= w_last_d;
            aw_done_q <= aw_done_d;
            wd_done_q <= wd_done_d;
            r_state_q <= r_state_d;
            r_gnt_q   <= r_gnt_d;
            r_last_q  <= r_last_d;
        end
    end

    // Done flags self-clear on the cycle both AW and W have completed.
    always_comb begin
        w_state_d = w_state_q;
        w_gnt_d   = w_gnt_q;
        w_last_d  = w_last_q;
        aw_done_d = aw_done_q;
        wd_done_d = wd_done_q;
        case (w_state_q)
            W_IDLE: if (s0_axil_awvalid | s1_axil_awvalid) begin
                w_gnt_d   = (s0_axil_awvalid & s1_axil_awvalid) ? ~w_last_q : s1_axil_awvalid;
                w_state_d = W_XFER;
            end
            W_XFER: begin
                aw_done_d = aw_ok & ~wd_ok;
                wd_done_d = wd_ok & ~aw_ok;
                w_state_d = (aw_ok & wd_ok) ? W_RESP : W_XFER;
            end
            W_RESP: if (b_hs) begin
                w_last_d  = w_gnt_q;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        m_axil_awaddr   = w_act ? (w_gnt_q ? s1_axil_awaddr : s0_axil_awaddr) : '0;
        m_axil_awprot   = w_act ? (w_gnt_q ? s1_axil_awprot : s0_axil_awprot) : '0;
        m_axil_wdata    = w_act ? (w_gnt_q ? s1_axil_wdata : s0_axil_wdata) : '0;
        m_axil_wstrb    = w_act ? (w_gnt_q ? s1_axil_wstrb : s0_axil_wstrb) : '0;
        m_axil_awvalid  = w_xfer & ~aw_done_q & (w_gnt_q ? s1_axil_awvalid : s0_axil_awvalid);
        m_axil_wvalid   = w_xfer & ~wd_done_q & (w_gnt_q ? s1_axil_wvalid : s0_axil_wvalid);
        m_axil_bready   = w_resp & (w_gnt_q ? s1_axil_bready : s0_axil_bready);
        s0_axil_awready = w_xfer & ~w_gnt_q & ~aw_done_q & m_axil_awready;
        s1_axil_awready = w_xfer & w_gnt_q & ~aw_done_q & m_axil_awready;
        s0_axil_wready  = w_xfer & ~w_gnt_q & ~wd_done_q & m_axil_wready;
        s1_axil_wready  = w_xfer & w_gnt_q & ~wd_done_q & m_axil_wready;
        s0_axil_bvalid  = w_resp & ~w_gnt_q & m_axil_bvalid;
        s1_axil_bvalid  = w_resp & w_gnt_q & m_axil_bvalid;
        s0_axil_bresp   = m_axil_bresp;
        s1_axil_bresp   = m_axil_bresp;
    end

    always_comb begin
        r_state_d = r_state_q;
        r_gnt_d   = r_gnt_q;
        r_last_d  = r_last_q;
        case (r_state_q)
            R_IDLE: if (s0_axil_arvalid | s1_axil_arvalid) begin
                r_gnt_d   = (s0_axil_arvalid & s1_axil_arvalid) ? ~r_last_q : s1_axil_arvalid;
                r_state_d = R_ADDR;
            end
            R_ADDR: r_state_d = ar_hs ? R_DATA : R_ADDR;
            R_DATA: if (rd_hs) begin
                r_last_d  = r_gnt_q;
                r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        m_axil_araddr   = r_act ? (r_gnt_q ? s1_axil_araddr : s0_axil_araddr) : '0;
        m_axil_arprot   = r_act ? (r_gnt_q ? s1_axil_arprot : s0_axil_arprot) : '0;
        m_axil_arvalid  = r_addr & (r_gnt_q ? s1_axil_arvalid : s0_axil_arvalid);
        m_axil_rready   = r_data & (r_gnt_q ? s1_axil_rready : s0_axil_rready);
        s0_axil_arready = r_addr & ~r_gnt_q & m_axil_arready;
        s1_axil_arready = r_addr & r_gnt_q & m_axil_arready;
        s0_axil_rvalid  = r_data & ~r_gnt_q & m_axil_rvalid;
        s1_axil_rvalid  = r_data & r_gnt_q & m_axil_rvalid;
        s0_axil_rdata   = m_axil_rdata;
        s1_axil_rdata   = m_axil_rdata;
        s0_axil_rresp   = m_axil_rresp;
        s1_axil_rresp   = m_axil_rresp;
    end

endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// tb_axil_arbiter_2x1: directed bench with two simple AXI-Lite masters and a register slave
// responder; expected addresses, data and ordering are written out per scenario.
module tb_axil_arbiter_2x1;
    localparam int AW = 40;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]   awaddr [2];
    logic [AW-1:0]   araddr [2];
    logic [DW-1:0]   wdata [2];
    logic            awv [2];
    logic            wv [2];
    logic            arv [2];
    logic [2:0]      prot = 3'd0;
    logic [DW/8-1:0] strb = '1;
    logic            rdy = 1'b1;
    logic            awr [2];
    logic            wrdy [2];
    logic            bvo [2];
    logic            arr [2];
    logic            rvo [2];
    logic [1:0]      bres [2];
    logic [1:0]      rres [2];
    logic [DW-1:0]   rdo [2];
    logic [AW-1:0]   m_awaddr, m_araddr;
    logic [2:0]      m_awprot, m_arprot;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic            m_bvalid, m_rvalid;
    logic [1:0]      m_bresp, m_rresp;
    logic [14:0]     ovec;

    axil_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .mpsoc_clk_100(clk), .axil_arst_n(rst_n),
        .s0_axil_awaddr(awaddr[0]), .s0_axil_awprot(prot), .s0_axil_awvalid(awv[0]), .s0_axil_awready(awr[0]),
        .s0_axil_wdata(wdata[0]), .s0_axil_wstrb(strb), .s0_axil_wvalid(wv[0]), .s0_axil_wready(wrdy[0]),
        .s0_axil_bresp(bres[0]), .s0_axil_bvalid(bvo[0]), .s0_axil_bready(rdy),
        .s0_axil_araddr(araddr[0]), .s0_axil_arprot(prot), .s0_axil_arvalid(arv[0]), .s0_axil_arready(arr[0]),
        .s0_axil_rdata(rdo[0]), .s0_axil_rresp(rres[0]), .s0_axil_rvalid(rvo[0]), .s0_axil_rready(rdy),
        .s1_axil_awaddr(awaddr[1]), .s1_axil_awprot(prot), .s1_axil_awvalid(awv[1]), .s1_axil_awready(awr[1]),
        .s1_axil_wdata(wdata[1]), .s1_axil_wstrb(strb), .s1_axil_wvalid(wv[1]), .s1_axil_wready(wrdy[1]),
        .s1_axil_bresp(bres[1]), .s1_axil_bvalid(bvo[1]), .s1_axil_bready(rdy),
        .s1_axil_araddr(araddr[1]), .s1_axil_arprot(prot), .s1_axil_arvalid(arv[1]), .s1_axil_arready(arr[1]),
        .s1_axil_rdata(rdo[1]), .s1_axil_rresp(rres[1]), .s1_axil_rvalid(rvo[1]), .s1_axil_rready(rdy),
        .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid), .m_axil_awready(rdy),
        .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(rdy),
        .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
        .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(rdy),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
    );

    assign ovec = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                   awr[0], wrdy[0], bvo[0], arr[0], rvo[0], awr[1], wrdy[1], bvo[1], arr[1], rvo[1]};

    logic [AW-1:0] wr_addr [2][8];
    logic [DW-1:0] wr_data [2][8];
    logic [AW-1:0] rd_addr [2][8];
    int            wr_n [2], wr_i [2], rd_n [2], rd_i [2], wcnt [2], wdly [2];
    logic          wbusy [2], wsent [2], rbusy [2];
    logic [1:0]    b_log [2][8];
    logic [DW-1:0] r_dlog [2][8];
    logic [1:0]    r_rlog [2][8];
    int            b_cnt [2], b_cyc [2], r_cnt [2], r_cyc [2];
    logic [AW-1:0] aw_log [16], ar_log [16];
    logic [DW-1:0] w_log [16];
    int            aw_cyc [16];
    int            aw_n, ar_n, w_n;
    logic          s_awg, s_wg, s_bp, s_rp;
    int            s_bcnt, s_bdly, s_rcnt;
    logic [AW-1:0] s_ra;
    int            cyc, n_chk, n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes before the edge takes effect, then advance masters and slave.
    task automatic step();
        logic [1:0] aw_h, w_h, b_h, ar_h, r_h, bres_s [2], rres_s [2];
        logic [DW-1:0] rdo_s [2], mw_d;
        logic [AW-1:0] maw_a, mar_a;
        logic maw_h, mw_h, mb_h, mar_h, mr_h;
        @(posedge clk);
        for (int x = 0; x < 2; x++) begin
            aw_h[x] = awv[x] & awr[x];
            w_h[x] = wv[x] & wrdy[x];
            b_h[x] = bvo[x];
            ar_h[x] = arv[x] & arr[x];
            r_h[x] = rvo[x];
            bres_s[x] = bres[x];
            rres_s[x] = rres[x];
            rdo_s[x] = rdo[x];
        end
        maw_h = m_awvalid; maw_a = m_awaddr;
        mw_h = m_wvalid; mw_d = m_wdata;
        mb_h = m_bvalid & m_bready;
        mar_h = m_arvalid; mar_a = m_araddr;
        mr_h = m_rvalid & m_rready;
        #1;
        cyc++;
        for (int x = 0; x < 2; x++) begin
            if (aw_h[x]) awv[x] = 1'b0;
            if (w_h[x]) begin wv[x] = 1'b0; wsent[x] = 1'b1; end
            if (b_h[x]) begin
                b_log[x][b_cnt[x]] = bres_s[x]; b_cnt[x]++; b_cyc[x] = cyc; wbusy[x] = 1'b0;
            end
            if (!wbusy[x] && wr_i[x] < wr_n[x]) begin
                awv[x] = 1'b1; awaddr[x] = wr_addr[x][wr_i[x]]; wdata[x] = wr_data[x][wr_i[x]];
                wcnt[x] = wdly[x]; wsent[x] = 1'b0; wbusy[x] = 1'b1; wr_i[x]++;
            end
            if (wbusy[x] && !wsent[x] && !wv[x]) begin
                if (wcnt[x] == 0) wv[x] = 1'b1;
                else wcnt[x]--;
            end
            if (ar_h[x]) arv[x] = 1'b0;
            if (r_h[x]) begin
                r_dlog[x][r_cnt[x]] = rdo_s[x]; r_rlog[x][r_cnt[x]] = rres_s[x];
                r_cnt[x]++; r_cyc[x] = cyc; rbusy[x] = 1'b0;
            end
            if (!rbusy[x] && rd_i[x] < rd_n[x]) begin
                arv[x] = 1'b1; araddr[x] = rd_addr[x][rd_i[x]]; rbusy[x] = 1'b1; rd_i[x]++;
            end
        end
        if (maw_h) begin aw_log[aw_n] = maw_a; aw_cyc[aw_n] = cyc; aw_n++; s_awg = 1'b1; end
        if (mw_h) begin w_log[w_n] = mw_d; w_n++; s_wg = 1'b1; end
        if (mb_h) m_bvalid = 1'b0;
        if (s_awg && s_wg) begin s_awg = 1'b0; s_wg = 1'b0; s_bp = 1'b1; s_bcnt = s_bdly; end
        if (s_bp) begin
            if (s_bcnt == 0) begin m_bvalid = 1'b1; m_bresp = 2'b00; s_bp = 1'b0; end
            else s_bcnt--;
        end
        if (mr_h) m_rvalid = 1'b0;
        if (mar_h) begin ar_log[ar_n] = mar_a; ar_n++; s_rp = 1'b1; s_rcnt = 0; s_ra = mar_a; end
        if (s_rp) begin
            if (s_rcnt == 0) begin
                m_rvalid = 1'b1; m_rdata = s_ra[31:0] ^ 32'hC0DE0000;
                m_rresp = (s_ra == 40'hBAD0) ? 2'b10 : 2'b00; s_rp = 1'b0;
            end else s_rcnt--;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int x = 0; x < 2; x++) begin
            awv[x] = 1'b0; wv[x] = 1'b0; arv[x] = 1'b0;
            awaddr[x] = '0; araddr[x] = '0; wdata[x] = '0;
            wr_n[x] = 0; wr_i[x] = 0; rd_n[x] = 0; rd_i[x] = 0; wcnt[x] = 0; wdly[x] = 0;
            wbusy[x] = 1'b0; wsent[x] = 1'b0; rbusy[x] = 1'b0;
            b_cnt[x] = 0; b_cyc[x] = 0; r_cnt[x] = 0; r_cyc[x] = 0;
        end
        aw_n = 0; ar_n = 0; w_n = 0;
        s_awg = 1'b0; s_wg = 1'b0; s_bp = 1'b0; s_rp = 1'b0; s_bcnt = 0; s_bdly = 0; s_rcnt = 0; s_ra = '0;
        m_bvalid = 1'b0; m_rvalid = 1'b0; m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic push_w(input int x, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[x][wr_n[x]] = a; wr_data[x][wr_n[x]] = d; wr_n[x]++;
    endtask

    task automatic push_r(input int x, input logic [AW-1:0] a);
        rd_addr[x][rd_n[x]] = a; rd_n[x]++;
    endtask

    function automatic logic all_done();
        logic d = 1'b1;
        for (int x = 0; x < 2; x++)
            d &= !wbusy[x] && !rbusy[x] && wr_i[x] == wr_n[x] && rd_i[x] == rd_n[x];
        return d;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (!all_done() && i < budget) begin step(); i++; end
        chk(tag, all_done(), 1);
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0;
        do_reset();
        chk("rst_vr", ovec, 0);
        chk("rst_pay", |{m_awaddr, m_araddr, m_wdata, m_wstrb}, 0);

        push_w(0, 40'h10, 32'hDEADBEEF);
        step();
        chk("t1_lat", m_awvalid, 0);
        step();
        chk("t1_awv", {m_awvalid, m_wvalid}, 2'b11);
        chk("t1_awaddr", m_awaddr, 40'h10);
        chk("t1_wdata", m_wdata, 32'hDEADBEEF);
        chk("t1_awr", {awr[1], awr[0]}, 2'b01);
        wait_done("t1_done", 50);
        chk("t1_b0", b_cnt[0], 1);
        chk("t1_b1", b_cnt[1], 0);
        chk("t1_bresp", b_log[0][0], 2'b00);
        chk("t1_wlog", w_log[0], 32'hDEADBEEF);

        do_reset();
        push_w(0, 40'h4, 32'h4444);
        push_w(1, 40'h8, 32'h8888);
        step();
        step();
        chk("t2_gnt", {awr[1], awr[0]}, 2'b01);
        wait_done("t2_done", 60);
        chk("t2_aw0", aw_log[0], 40'h4);
        chk("t2_aw1", aw_log[1], 40'h8);
        chk("t2_w1", w_log[1], 32'h8888);
        chk("t2_b", {b_cnt[1][3:0], b_cnt[0][3:0]}, 8'h11);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_r(0, 40'h100 + 40'(4 * i));
            push_r(1, 40'h200 + 40'(4 * i));
        end
        wait_done("t3_done", 300);
        for (int i = 0; i < 16; i++)
            chk("t3_order", ar_log[i], ((i % 2) == 0 ? 40'h100 : 40'h200) + 40'(4 * (i / 2)));
        for (int i = 0; i < 8; i++) begin
            chk("t3_d0", r_dlog[0][i], 32'hC0DE0100 + 32'(4 * i));
            chk("t3_d1", r_dlog[1][i], 32'hC0DE0200 + 32'(4 * i));
        end

        do_reset();
        s_bdly = 5;
        wdly[0] = 3;
        push_w(0, 40'h20, 32'h1234);
        step();
        push_w(1, 40'h30, 32'h5678);
        push_r(1, 40'h40);
        wait_done("t4_done", 100);
        chk("t4_aw0", aw_log[0], 40'h20);
        chk("t4_aw1", aw_log[1], 40'h30);
        chk("t4_w0", w_log[0], 32'h1234);
        chk("t4_hold", aw_cyc[1], b_cyc[0] + 2);
        chk("t4_rd_early", r_cyc[1] < b_cyc[0], 1);
        chk("t4_rdata", r_dlog[1][0], 32'hC0DE0040);

        do_reset();
        push_r(0, 40'h50);
        push_r(1, 40'hBAD0);
        wait_done("t5_done", 60);
        chk("t5_order", ar_log[0], 40'h50);
        chk("t5_r1resp", r_rlog[1][0], 2'b10);
        chk("t5_r1data", r_dlog[1][0], 32'hC0DEBAD0);
        chk("t5_r0resp", r_rlog[0][0], 2'b00);
        chk("t5_r0data", r_dlog[0][0], 32'hC0DE0050);

        do_reset();
        s_bdly = 10;
        push_w(0, 40'h90, 32'h9);
        for (int i = 0; i < 20 && !m_bready; i++) step();
        chk("t6_resp", m_bready, 1);
        rst_n = 1'b0;
        push_w(1, 40'h60, 32'h6060);
        push_r(1, 40'h64);
        step();
        chk("t6_rst_vr", ovec, 0);
        chk("t6_rst_pay", |{m_awaddr, m_araddr, m_wdata, m_wstrb}, 0);
        do_reset();
        push_w(1, 40'h60, 32'h6060);
        wait_done("t6_s1_done", 60);
        chk("t6_b1", b_cnt[1], 1);
        chk("t6_aw", aw_log[0], 40'h60);
        push_w(0, 40'h70, 32'h7070);
        push_w(1, 40'h74, 32'h7474);
        wait_done("t6_cont_done", 60);
        chk("t6_aw_s0", aw_log[1], 40'h70);
        chk("t6_aw_s1", aw_log[2], 40'h74);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/axil_arbiter_2x1.md
# axil_arbiter_2x1

Two-master to one-slave AXI4-Lite arbiter for the PS HPM0_FPD register fabric. It lets two AXI-Lite masters share a single downstream register slave, such as the correlator control/readout bank. Examples of the two masters are the PS port and an on-fabric sequencer. Read and write directions are arbitrated independently, each round-robin with one outstanding transaction per direction.

## Interface
Parameters:
- ADDR_WIDTH, 40, address width on all ports.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.

Ports (x = 0,1 for the two upstream masters; widths follow AXI-Lite with the above parameters):
- mpsoc_clk_100  in  1  single clock for all ports.
- axil_arst_n  in  1  reset, synchronous and active-low.
- sx_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  write address from master x.
- sx_axil_awready  out  1  write-address accept to master x.
- sx_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1  write data from master x.
- sx_axil_wready  out  1  write-data accept to master x.
- sx_axil_bresp/bvalid  out  2/1  write response to master x.
- sx_axil_bready  in  1  write-response accept from master x.
- sx_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1  read address from master x.
- sx_axil_arready  out  1  read-address accept to master x.
- sx_axil_rdata/rresp/rvalid  out  DATA_WIDTH/2/1  read data to master x.
- sx_axil_rready  in  1  read-data accept from master x.
- m_axil_*  mirror set, opposite directions, same widths  downstream slave port.

## Operation
- Write FSM states:
  - W_IDLE: wait for a write request.
  - W_XFER: forward AW and W independently.
  - W_RESP: wait for m_axil_bvalid.
- Read FSM states:
  - R_IDLE: wait for a read request.
  - R_ADDR: forward AR.
  - R_DATA: wait for m_axil_rvalid.
- Request definition: a write request is sx_awvalid only; a read request is sx_arvalid.
- Grant in W_IDLE/R_IDLE when any request is present:
  - Only one requester: grant it.
  - Both request: grant the master not granted last in that direction.
  - The last-grant pointer resets to 1, so s0 wins the first contention.
- W_XFER forwarding:
  - While granted, m_awvalid follows sg_awvalid and sg_awready follows m_awready (combinational).
  - The W channel is forwarded the same way.
  - Per-channel "done" flags record each handshake.
  - Move to W_RESP once both AW and W have handshaken, in either order or the same cycle.
- W_RESP: m_bvalid/bresp are routed to the granted master and sg_bready to m_bready. On the B handshake, update the pointer and return to W_IDLE.
- R_ADDR/R_DATA: same scheme. The AR handshake moves to R_DATA; the R handshake returns to R_IDLE and updates the pointer.
- Non-granted master: sees awready/wready/arready = 0 and bvalid/rvalid = 0; its requests are held off, never dropped.
- Payload muxing: m_axil address/prot/data/strb are muxed from the granted master and are 0 in IDLE. sx rdata/rresp/bresp are driven from m_axil for both masters; the valids gate them.
- Both directions may be in flight concurrently, from the same or different masters.
- Responses pass through unmodified, including SLVERR/DECERR.

## Timing
- Grant is registered: a request first seen at edge N gives m_axil_*valid high in cycle N+1.
- Minimum write occupancy is 3 cycles: grant, AW+W, B. Minimum read occupancy is 3 cycles.
- The next grant in a direction is evaluated in the cycle after the returning handshake, giving 1 idle cycle between back-to-back transactions.
- No combinational path from m_axil ready to m_axil valid.
- Reset (axil_arst_n low at a clock edge):
  - Both FSMs go to IDLE, done flags clear, pointer = 1.
  - All valid and ready outputs on every port are 0; muxed payloads are 0.
  - Reset mid-transaction abandons it. Upstream and downstream must be reset together.
- Simultaneous events:
  - A request arriving in the same cycle as a response completion waits for IDLE and is then arbitrated normally.
  - A W arriving before AW is accepted as soon as granted, since grant depends on AW only.

## Test plan
- Single write s0 addr 0x10 data 0xDEADBEEF -> m_axil sees awaddr 0x10, wdata 0xDEADBEEF one cycle after awvalid; bresp OKAY returned to s0 only; s1 sees no bvalid.
- Both masters assert awvalid on the same cycle after reset (s0→0x4, s1→0x8) -> s0 served first, then s1; m_axil order is 0x4, 0x8.
- Continuous reads from both masters, 8 each -> grants strictly alternate s0, s1, …; each gets 8 rdata beats with correct values.
- s0 write with wvalid 3 cycles after awvalid, and m_axil_bvalid delayed 5 cycles -> no s1 write granted until B completes; s1 read issued concurrently completes during the wait.
- Downstream returns rresp SLVERR to s1 read -> s1 receives rresp 2'b10, s0 unaffected.
- Reset pulsed while in W_RESP -> next cycle all valid/ready outputs are 0; a fresh s1 write afterward completes normally with s0 priority restored on the next contention.
